// File: rtl/bcd_accum_if.sv
// Request/response bundle for the BCD accumulator. The master issues load/start requests
// and the slave returns status and the accumulated value.
interface bcd_accum_if #(
    parameter int unsigned DIGITS = 4
);
    localparam int unsigned W = 4 * DIGITS;

    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic         op;
    logic [W-1:0] operand;
    logic         busy;
    logic         done;
    logic [W-1:0] value;
    logic         ovf;
    logic         unf;
    logic         zero;

    modport master (
        output load, load_val, start, op, operand,
        input  busy, done, value, ovf, unf, zero
    );

    modport slave (
        input  load, load_val, start, op, operand,
        output busy, done, value, ovf, unf, zero
    );
endinterface

// File: rtl/bcd_accum.sv
// N-digit BCD accumulator. It adds or subtracts a BCD operand one digit per clock and
// commits the whole result in a single cycle, either saturated or wrapped.
module bcd_accum #(
    parameter int unsigned          DIGITS = 4,
    parameter logic [4*DIGITS-1:0]  INIT   = '0,
    parameter bit                   SAT    = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    bcd_accum_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
    localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          op_q, op_d;
    logic [W-1:0]  opd_q, opd_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  value_q, value_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic [W-1:0]  opd_clamped;
    logic [3:0]    a_dig, b_dig, sum_dig;
    logic [4:0]    t;
    logic          t_carry;

    // Digits above 9 are forced to 9 as the operand is latched
    always_comb begin
        opd_clamped = bus.operand;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bus.operand[4*i +: 4] > 4'd9) opd_clamped[4*i +: 4] = 4'd9;
        end
    end

    // Single-digit BCD adder; subtraction uses the nines' complement plus an initial carry
    always_comb begin
        a_dig   = acc_q[4*idx_q +: 4];
        b_dig   = op_q ? 4'(4'd9 - opd_q[4*idx_q +: 4]) : opd_q[4*idx_q +: 4];
        t       = 5'(a_dig) + 5'(b_dig) + 5'(carry_q);
        t_carry = (t > 5'd9);
        sum_dig = t_carry ? 4'(t - 5'd10) : t[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        op_d    = op_q;
        opd_d   = opd_q;
        acc_d   = acc_q;
        value_d = value_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        done_d  = 1'b0;

        if (bus.load) begin
            state_d = IDLE;
            value_d = bus.load_val;
            ovf_d   = 1'b0;
            unf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        op_d    = bus.op;
                        opd_d   = opd_clamped;
                        acc_d   = value_q;
                        idx_d   = '0;
                        carry_d = bus.op;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    acc_d[4*idx_q +: 4] = sum_dig;
                    carry_d = t_carry;
                    if (idx_q == LAST) state_d = FINISH;
                    else               idx_d   = IW'(idx_q + 1'b1);
                end
                FINISH: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                    value_d = acc_q;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    // Add carry-out is overflow; subtract with no carry-out is a borrow
                    if (!op_q && carry_q) begin
                        ovf_d = 1'b1;
                        if (SAT) value_d = ALL9;
                    end else if (op_q && !carry_q) begin
                        unf_d = 1'b1;
                        if (SAT) value_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            op_q    <= 1'b0;
            opd_q   <= '0;
            acc_q   <= '0;
            value_q <= INIT;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            op_q    <= op_d;
            opd_q   <= opd_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.value = value_q;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
    assign bus.zero  = (value_q == '0);
endmodule

// File: tb/tb_bcd_accum.sv
// Bench for bcd_accum: four configurations run side by side against a decimal-arithmetic
// reference model.
module tb_bcd_accum;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, load, op;
    logic [3:0]  start_v;
    logic [31:0] lv, opd;

    localparam int          DIG   [4] = '{4, 4, 1, 8};
    localparam bit          SATP  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    localparam logic [31:0] INITV [4] = '{32'h0, 32'h42, 32'h0, 32'h0};

    bcd_accum_if #(.DIGITS(4)) if0 ();
    bcd_accum_if #(.DIGITS(4)) if1 ();
    bcd_accum_if #(.DIGITS(1)) if2 ();
    bcd_accum_if #(.DIGITS(8)) if3 ();

    assign if0.load = load; assign if0.load_val = lv[15:0]; assign if0.start = start_v[0];
    assign if0.op   = op;   assign if0.operand  = opd[15:0];
    assign if1.load = load; assign if1.load_val = lv[15:0]; assign if1.start = start_v[1];
    assign if1.op   = op;   assign if1.operand  = opd[15:0];
    assign if2.load = load; assign if2.load_val = lv[3:0];  assign if2.start = start_v[2];
    assign if2.op   = op;   assign if2.operand  = opd[3:0];
    assign if3.load = load; assign if3.load_val = lv;       assign if3.start = start_v[3];
    assign if3.op   = op;   assign if3.operand  = opd;

    bcd_accum #(.DIGITS(4), .INIT(16'h0000), .SAT(1'b1)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    bcd_accum #(.DIGITS(4), .INIT(16'h0042), .SAT(1'b0)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    bcd_accum #(.DIGITS(1), .INIT(4'h0),     .SAT(1'b0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));
    bcd_accum #(.DIGITS(8), .INIT(32'h0),    .SAT(1'b1)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));

    logic [31:0] val_o [4];
    logic [3:0]  busy_o, done_o, ovf_o, unf_o, zero_o;
    assign val_o[0] = 32'(if0.value); assign val_o[1] = 32'(if1.value);
    assign val_o[2] = 32'(if2.value); assign val_o[3] = if3.value;
    assign busy_o = {if3.busy, if2.busy, if1.busy, if0.busy};
    assign done_o = {if3.done, if2.done, if1.done, if0.done};
    assign ovf_o  = {if3.ovf,  if2.ovf,  if1.ovf,  if0.ovf};
    assign unf_o  = {if3.unf,  if2.unf,  if1.unf,  if0.unf};
    assign zero_o = {if3.zero, if2.zero, if1.zero, if0.zero};

    int     n_pass = 0, n_total = 0;
    longint mval [4];
    bit     movf [4], munf [4];

    function automatic longint p10(int d);
        longint r = 1;
        for (int i = 0; i < d; i++) r = r * 10;
        return r;
    endfunction

    // Decimal value of the low d digits, digits above 9 read as 9
    function automatic longint to_dec(logic [31:0] x, int d);
        longint r = 0;
        logic [3:0] g;
        for (int i = d - 1; i >= 0; i--) begin
            g = x[4*i +: 4];
            r = r * 10 + longint'((g > 4'd9) ? 4'd9 : g);
        end
        return r;
    endfunction

    function automatic logic [31:0] to_bcd(longint v, int d);
        logic [31:0] r = '0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_bcd();
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 4; i++) begin
            mval[i] = to_dec(INITV[i], DIG[i]); movf[i] = 1'b0; munf[i] = 1'b0;
        end
    endtask

    task automatic m_load(logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            mval[i] = to_dec(v, DIG[i]); movf[i] = 1'b0; munf[i] = 1'b0;
        end
    endtask

    task automatic m_op(int i, bit o, logic [31:0] b);
        longint x, lim, r;
        x   = to_dec(b, DIG[i]);
        lim = p10(DIG[i]);
        r   = o ? mval[i] - x : mval[i] + x;
        movf[i] = 1'b0; munf[i] = 1'b0;
        if (!o && r >= lim) begin
            movf[i] = 1'b1; r = SATP[i] ? lim - 1 : r - lim;
        end else if (o && r < 0) begin
            munf[i] = 1'b1; r = SATP[i] ? 0 : r + lim;
        end
        mval[i] = r;
    endtask

    task automatic chk(string tag, int u, logic [31:0] obs, logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s u%0d observed=%h expected=%h", tag, u, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_state(string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_val"},  i, val_o[i], to_bcd(mval[i], DIG[i]));
            chk({tag, "_ovf"},  i, 32'(ovf_o[i]),  32'(movf[i]));
            chk({tag, "_unf"},  i, 32'(unf_o[i]),  32'(munf[i]));
            chk({tag, "_zero"}, i, 32'(zero_o[i]), 32'(mval[i] == 0));
            chk({tag, "_busy"}, i, 32'(busy_o[i]), 32'd0);
        end
    endtask

    // Watch a quiet window: nothing may be busy or pulse done
    task automatic quiet(string tag);
        int act [4] = '{0, 0, 0, 0};
        for (int c = 0; c < 14; c++) begin
            for (int i = 0; i < 4; i++) if (busy_o[i] || done_o[i]) act[i]++;
            tick();
        end
        for (int i = 0; i < 4; i++) chk({tag, "_quiet"}, i, 32'(act[i]), 32'd0);
    endtask

    task automatic do_load(logic [31:0] v);
        load = 1'b1; lv = v;
        tick();
        load = 1'b0;
        m_load(v);
        check_state("load");
    endtask

    // One operation on the selected units; poke re-asserts start mid-operation
    task automatic run_op(logic [3:0] sel, bit o, logic [31:0] b, bit poke);
        logic [31:0] old [4];
        int bcnt [4], dcnt [4], didx [4];
        bit held [4];
        for (int i = 0; i < 4; i++) begin
            old[i] = val_o[i]; bcnt[i] = 0; dcnt[i] = 0; didx[i] = -1; held[i] = 1'b1;
        end
        start_v = sel; op = o; opd = b;
        tick();
        start_v = '0; op = 1'($urandom); opd = $urandom;
        for (int idx = 0; idx < 14; idx++) begin
            for (int i = 0; i < 4; i++) begin
                if (busy_o[i]) bcnt[i]++;
                if (busy_o[i] && val_o[i] !== old[i]) held[i] = 1'b0;
                if (done_o[i]) begin dcnt[i]++; didx[i] = idx; end
            end
            if (poke && idx == 2) begin
                start_v = sel & 4'b1011; op = 1'($urandom); opd = $urandom;
            end else begin
                start_v = '0;
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
                m_op(i, o, b);
                chk("busy_cycles", i, 32'(bcnt[i]), 32'(DIG[i] + 1));
                chk("done_count",  i, 32'(dcnt[i]), 32'd1);
                chk("done_cycle",  i, 32'(didx[i]), 32'(DIG[i] + 1));
                chk("val_held",    i, 32'(held[i]), 32'd1);
            end else begin
                chk("idle_done", i, 32'(dcnt[i] + bcnt[i]), 32'd0);
            end
        end
        check_state("op");
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; start_v = '0; op = 1'b0; lv = '0; opd = '0;
        tick(); tick();
        rst = 1'b0;
        m_reset();
        check_state("reset");

        do_load(32'h00001234);
        run_op(4'hF, 1'b0, 32'h00000999, 1'b0);
        chk("add_2233", 0, val_o[0], 32'h2233);

        do_load(32'h00000005);
        run_op(4'hF, 1'b1, 32'h00000007, 1'b0);
        chk("sub_sat",   0, val_o[0], 32'h0000);
        chk("sub_unf",   0, 32'(unf_o[0]), 32'd1);
        chk("sub_zero",  0, 32'(zero_o[0]), 32'd1);
        chk("sub_wrap",  1, val_o[1], 32'h9998);
        chk("sub_unf_w", 1, 32'(unf_o[1]), 32'd1);

        do_load(32'h00009990);
        run_op(4'hF, 1'b0, 32'h00000020, 1'b0);
        chk("ovf_sat",  0, val_o[0], 32'h9999);
        chk("ovf_flag", 0, 32'(ovf_o[0]), 32'd1);
        chk("ovf_wrap", 1, val_o[1], 32'h0010);

        do_load(32'h00004500);
        run_op(4'hF, 1'b1, 32'h00004500, 1'b0);
        chk("exact0_val", 0, val_o[0], 32'h0000);
        chk("exact0_unf", 0, 32'(unf_o[0]), 32'd0);

        do_load(32'h00000003);
        run_op(4'hF, 1'b0, 32'h0000000C, 1'b0);
        chk("clamp_d1", 2, val_o[2], 32'h2);
        chk("clamp_ovf", 2, 32'(ovf_o[2]), 32'd1);

        do_load(32'h99999999);
        run_op(4'hF, 1'b0, 32'h00000001, 1'b0);
        chk("d8_sat", 3, val_o[3], 32'h99999999);
        chk("d8_ovf", 3, 32'(ovf_o[3]), 32'd1);

        // Start while busy is dropped
        do_load(rand_bcd());
        run_op(4'hF, 1'b0, rand_bcd(), 1'b1);

        // Load at digit 2 aborts the running operation
        start_v = 4'hF; op = 1'b0; opd = 32'h11111111;
        tick();
        start_v = '0;
        tick(); tick();
        load = 1'b1; lv = 32'h00002468;
        tick();
        load = 1'b0;
        m_load(32'h00002468);
        check_state("abort");
        quiet("abort");

        // Load and start together: load only
        load = 1'b1; lv = 32'h00000777; start_v = 4'hF; op = 1'b0; opd = 32'h00000111;
        tick();
        load = 1'b0; start_v = '0;
        m_load(32'h00000777);
        check_state("ldst");
        quiet("ldst");

        // Reset mid-operation
        start_v = 4'hF; op = 1'b1; opd = 32'h00000001;
        tick();
        start_v = '0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        check_state("rst_mid");
        quiet("rst_mid");

        // Back-to-back on the 4-digit units: start accepted in the done cycle
        do_load(32'h00001500);
        start_v = 4'b0011; op = 1'b0; opd = 32'h00000250;
        tick();
        start_v = '0;
        repeat (5) tick();
        chk("b2b_done", 0, 32'(done_o[0]), 32'd1);
        chk("b2b_busy", 0, 32'(busy_o[0]), 32'd0);
        start_v = 4'b0011; op = 1'b1; opd = 32'h00000075;
        tick();
        start_v = '0;
        repeat (14) tick();
        for (int i = 0; i < 2; i++) begin
            m_op(i, 1'b0, 32'h00000250);
            m_op(i, 1'b1, 32'h00000075);
        end
        check_state("b2b");
        chk("b2b_val", 0, val_o[0], 32'h1675);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 2) == 0) do_load(rand_bcd());
            run_op(4'($urandom_range(1, 15)), 1'($urandom), $urandom, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
